// File: rtl/onchip_memory_dp.sv
// Dual-port on-chip RAM with two Avalon-MM slaves on one clock.
// A clear sequencer fills the array with INIT_VALUE after reset. Read data
// returns through a clken-gated pipeline of READ_LATENCY stages per port.
// If both ports write the same word in the same cycle, s1 goes first and s2 is stalled.
module onchip_memory_dp #(
    parameter int unsigned              DATA_WIDTH     = 32,
    parameter int unsigned              ADDR_WIDTH     = 11,
    parameter int unsigned              DEPTH          = 2048,
    parameter int unsigned              READ_LATENCY   = 1,
    parameter bit                       CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0]    INIT_VALUE     = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clken,
    output logic                        init_done,

    input  logic [ADDR_WIDTH-1:0]       s1_address,
    input  logic                        s1_chipselect,
    input  logic                        s1_read,
    input  logic                        s1_write,
    input  logic [DATA_WIDTH/8-1:0]     s1_byteenable,
    input  logic [DATA_WIDTH-1:0]       s1_writedata,
    output logic                        s1_waitrequest,
    output logic [DATA_WIDTH-1:0]       s1_readdata,
    output logic                        s1_readdatavalid,

    input  logic [ADDR_WIDTH-1:0]       s2_address,
    input  logic                        s2_chipselect,
    input  logic                        s2_read,
    input  logic                        s2_write,
    input  logic [DATA_WIDTH/8-1:0]     s2_byteenable,
    input  logic [DATA_WIDTH-1:0]       s2_writedata,
    output logic                        s2_waitrequest,
    output logic [DATA_WIDTH-1:0]       s2_readdata,
    output logic                        s2_readdatavalid
);

    localparam int unsigned BeW     = DATA_WIDTH / 8;
    localparam int unsigned IdxW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned Lat     = READ_LATENCY;
    localparam logic [ADDR_WIDTH:0] DepthA  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IdxW-1:0]     LastIdx = IdxW'(DEPTH - 1);

    typedef enum logic [0:0] {StClear, StReady} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] clr_addr_q, clr_addr_d;
    logic            clr_we;

    // Port signals gathered into arrays; index 0 is s1, index 1 is s2.
    logic [1:0][ADDR_WIDTH-1:0] addr;
    logic [1:0][BeW-1:0]        be;
    logic [1:0][DATA_WIDTH-1:0] wdata;
    logic [1:0]                 cs, rd, wr;
    logic [1:0][IdxW-1:0]       idx;
    logic [1:0]                 in_rng, wr_acc, rd_acc, waitreq;
    logic [1:0][DATA_WIDTH-1:0] rd_word;
    logic                       wait_base, wr_coll;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [1:0][Lat-1:0]                 vld_q, vld_d;
    logic [1:0][Lat-1:0][DATA_WIDTH-1:0] dat_q, dat_d;

    assign addr  = {s2_address, s1_address};
    assign be    = {s2_byteenable, s1_byteenable};
    assign wdata = {s2_writedata, s1_writedata};
    assign cs    = {s2_chipselect, s1_chipselect};
    assign rd    = {s2_read, s1_read};
    assign wr    = {s2_write, s1_write};

    // Clear-sequencer state register; clken freezes it, reset restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= CLEAR_ON_RESET ? StClear : StReady;
            clr_addr_q <= '0;
        end else if (clken) begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // Clear-sequencer next state: one word per enabled cycle, then READY.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        clr_we     = 1'b0;
        unique case (state_q)
            StClear: begin
                clr_we     = 1'b1;
                clr_addr_d = clr_addr_q + IdxW'(1);
                if (clr_addr_q == LastIdx) begin
                    state_d    = StReady;
                    clr_addr_d = '0;
                end
            end
            StReady: begin
                state_d = StReady;
            end
        endcase
    end

    // Request decode: stall, accept and address range per port.
    always_comb begin
        wait_base = reset | (state_q != StReady) | ~clken;
        // Same-word write collision: s1 wins, s2 retries next cycle.
        wr_coll   = cs[0] & wr[0] & cs[1] & wr[1] & (addr[0] == addr[1]);
        waitreq   = {wait_base | wr_coll, wait_base};
        wr_acc    = '0;
        rd_acc    = '0;
        in_rng    = '0;
        idx       = '0;
        rd_word   = '0;
        for (int p = 0; p < 2; p++) begin
            wr_acc[p] = cs[p] & wr[p] & ~waitreq[p];
            // Read and write together is a write only.
            rd_acc[p] = cs[p] & rd[p] & ~wr[p] & ~waitreq[p];
            in_rng[p] = {1'b0, addr[p]} < DepthA;
            idx[p]    = addr[p][IdxW-1:0];
            if (in_rng[p]) begin
                rd_word[p] = mem[idx[p]];
            end
        end
    end

    // RAM array: clear writes plus byte-masked port writes; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (clr_we && clken && !reset) begin
            mem[clr_addr_q] <= INIT_VALUE;
        end
        for (int p = 0; p < 2; p++) begin
            if (wr_acc[p] && in_rng[p]) begin
                for (int b = 0; b < BeW; b++) begin
                    if (be[p][b]) begin
                        mem[idx[p]][b*8 +: 8] <= wdata[p][b*8 +: 8];
                    end
                end
            end
        end
    end

    // Read pipeline next state. Data stages load only behind a valid,
    // so the last stage keeps the most recent result between pulses.
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (clken) begin
            for (int p = 0; p < 2; p++) begin
                vld_d[p][0] = rd_acc[p];
                if (rd_acc[p]) begin
                    dat_d[p][0] = rd_word[p];
                end
                for (int k = 1; k < Lat; k++) begin
                    vld_d[p][k] = vld_q[p][k-1];
                    if (vld_q[p][k-1]) begin
                        dat_d[p][k] = dat_q[p][k-1];
                    end
                end
            end
        end
    end

    // Read pipeline registers; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign init_done        = (state_q == StReady);
    assign s1_waitrequest   = waitreq[0];
    assign s2_waitrequest   = waitreq[1];
    // A pulse held by clken=0 stays in the last stage and shows once clken returns.
    assign s1_readdatavalid = vld_q[0][Lat-1] & clken & ~reset;
    assign s2_readdatavalid = vld_q[1][Lat-1] & clken & ~reset;
    assign s1_readdata      = dat_q[0][Lat-1];
    assign s2_readdata      = dat_q[1][Lat-1];

endmodule

// File: tb/tb_onchip_memory_dp.sv
// Bench for onchip_memory_dp: two instances (read latency 2 and 3) share one
// stimulus stream and are checked every cycle against a transaction-level model.
module tb_onchip_memory_dp;

    localparam int          Depth = 16;
    localparam logic [31:0] Init  = 32'hA5A5A5A5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst, cken;
    logic [1:0]            cs, rd, wr;
    logic [1:0][4:0]       addr;
    logic [1:0][3:0]       be;
    logic [1:0][31:0]      wd;
    logic [1:0]            done_o;
    logic [1:0][1:0]       wait_o, rdv_o;
    logic [1:0][1:0][31:0] rdd_o;

    onchip_memory_dp #(
        .DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(Depth), .READ_LATENCY(2),
        .CLEAR_ON_RESET(1'b1), .INIT_VALUE(Init)
    ) u_dut_l2 (
        .clk(clk), .reset(rst), .clken(cken), .init_done(done_o[0]),
        .s1_address(addr[0]), .s1_chipselect(cs[0]), .s1_read(rd[0]), .s1_write(wr[0]),
        .s1_byteenable(be[0]), .s1_writedata(wd[0]), .s1_waitrequest(wait_o[0][0]),
        .s1_readdata(rdd_o[0][0]), .s1_readdatavalid(rdv_o[0][0]),
        .s2_address(addr[1]), .s2_chipselect(cs[1]), .s2_read(rd[1]), .s2_write(wr[1]),
        .s2_byteenable(be[1]), .s2_writedata(wd[1]), .s2_waitrequest(wait_o[0][1]),
        .s2_readdata(rdd_o[0][1]), .s2_readdatavalid(rdv_o[0][1])
    );

    onchip_memory_dp #(
        .DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(Depth), .READ_LATENCY(3),
        .CLEAR_ON_RESET(1'b1), .INIT_VALUE(Init)
    ) u_dut_l3 (
        .clk(clk), .reset(rst), .clken(cken), .init_done(done_o[1]),
        .s1_address(addr[0]), .s1_chipselect(cs[0]), .s1_read(rd[0]), .s1_write(wr[0]),
        .s1_byteenable(be[0]), .s1_writedata(wd[0]), .s1_waitrequest(wait_o[1][0]),
        .s1_readdata(rdd_o[1][0]), .s1_readdatavalid(rdv_o[1][0]),
        .s2_address(addr[1]), .s2_chipselect(cs[1]), .s2_read(rd[1]), .s2_write(wr[1]),
        .s2_byteenable(be[1]), .s2_writedata(wd[1]), .s2_waitrequest(wait_o[1][1]),
        .s2_readdata(rdd_o[1][1]), .s2_readdatavalid(rdv_o[1][1])
    );

    // Reference model state.
    typedef struct packed {
        logic [31:0] due;
        logic [31:0] data;
    } rd_t;

    logic [31:0] m_mem [Depth];
    rd_t         pend [4][$];    // index = instance*2 + port
    logic [31:0] m_last [4];
    int          m_en;           // count of clken=1 edges since reset
    bit          m_ready;
    int          m_clr;
    int          n_vec = 0;
    int          n_err = 0;

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : 3;
    endfunction

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic idle();
        cs = '0; rd = '0; wr = '0; addr = '0; be = '0; wd = '0;
    endtask

    task automatic model_reset();
        m_ready = 1'b0;
        m_clr   = 0;
        m_en    = 0;
        for (int k = 0; k < 4; k++) begin
            pend[k].delete();
            m_last[k] = '0;
        end
    endtask

    // One clock: compare all outputs mid-cycle, then advance the model at the edge.
    task automatic step();
        logic        wbase, coll, pulse;
        logic [1:0]  wexp, racc, wacc;
        logic [31:0] dexp, rword;
        logic [3:0]  shown;
        int          k;
        @(negedge clk);
        wbase = rst | ~m_ready | ~cken;
        coll  = cs[0] & wr[0] & cs[1] & wr[1] & (addr[0] == addr[1]);
        wexp  = {wbase | coll, wbase};
        for (int p = 0; p < 2; p++) begin
            wacc[p] = cs[p] & wr[p] & ~wexp[p];
            racc[p] = cs[p] & rd[p] & ~wr[p] & ~wexp[p];
        end
        shown = '0;
        for (int i = 0; i < 2; i++) begin
            check_value($sformatf("init_done_l%0d", lat_of(i)), 32'(done_o[i]), 32'(m_ready));
            for (int p = 0; p < 2; p++) begin
                k     = i * 2 + p;
                pulse = ~rst & cken & (pend[k].size() > 0);
                if (pulse) pulse = (pend[k][0].due == 32'(m_en));
                shown[k] = pulse;
                check_value($sformatf("waitreq_l%0d_s%0d", lat_of(i), p + 1),
                            32'(wait_o[i][p]), 32'(wexp[p]));
                check_value($sformatf("rdvalid_l%0d_s%0d", lat_of(i), p + 1),
                            32'(rdv_o[i][p]), 32'(pulse));
                if (!rst && cken) begin
                    dexp = pulse ? pend[k][0].data : m_last[k];
                    check_value($sformatf("rddata_l%0d_s%0d", lat_of(i), p + 1),
                                rdd_o[i][p], dexp);
                end
            end
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (cken) begin
            for (int j = 0; j < 4; j++) begin
                if (shown[j]) begin
                    m_last[j] = pend[j][0].data;
                    void'(pend[j].pop_front());
                end
            end
            m_en++;
            // Reads see memory before this edge's writes.
            for (int p = 0; p < 2; p++) begin
                if (racc[p]) begin
                    rword = (addr[p] < 5'(Depth)) ? m_mem[addr[p][3:0]] : 32'h0;
                    for (int i = 0; i < 2; i++) begin
                        pend[i*2+p].push_back('{due: 32'(m_en + lat_of(i) - 1), data: rword});
                    end
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (wacc[p] && addr[p] < 5'(Depth)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be[p][b]) m_mem[addr[p][3:0]][b*8 +: 8] = wd[p][b*8 +: 8];
                    end
                end
            end
            if (!m_ready) begin
                m_mem[m_clr] = Init;
                m_clr++;
                if (m_clr == Depth) m_ready = 1'b1;
            end
        end
        #1;
    endtask

    task automatic do_write(input int p, input logic [4:0] a, input logic [3:0] b,
                            input logic [31:0] d);
        idle();
        cs[p] = 1'b1; wr[p] = 1'b1; addr[p] = a; be[p] = b; wd[p] = d;
        step();
        idle();
    endtask

    // Single read on the latency-2 instance with explicit latency and data checks.
    task automatic read_expect(input int p, input logic [4:0] a, input logic [31:0] exp,
                               input string tag);
        int n;
        idle();
        cs[p] = 1'b1; rd[p] = 1'b1; addr[p] = a;
        step();
        idle();
        n = 1;
        while (!rdv_o[0][p] && n < 10) begin
            step();
            n++;
        end
        check_value({tag, "_latency"}, 32'(n), 32'd2);
        if (rdv_o[0][p]) check_value({tag, "_data"}, rdd_o[0][p], exp);
        step();
    endtask

    // Counts cycles until init_done rises, bounded.
    task automatic clear_and_count(input string tag);
        int n;
        n = 0;
        while (!done_o[0] && n < 100) begin
            step();
            n++;
        end
        check_value(tag, 32'(n), 32'(Depth));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cken = 1'b1; idle();
        model_reset();
        step(); step();
        rst = 1'b0;

        // Clear sequence then readback of every word.
        clear_and_count("clear_cycles");
        for (int a = 0; a < Depth; a++) begin
            idle(); cs[a % 2] = 1'b1; rd[a % 2] = 1'b1; addr[a % 2] = 5'(a);
            step();
        end
        idle(); repeat (4) step();

        // Latency-2 read of freshly written data, then back-to-back reads.
        do_write(0, 5'd5, 4'hF, 32'h11223344);
        read_expect(0, 5'd5, 32'h11223344, "rd_addr5");
        for (int a = 0; a < 4; a++) begin
            idle(); cs[0] = 1'b1; rd[0] = 1'b1; addr[0] = 5'(a + 4);
            step();
        end
        idle(); repeat (4) step();

        // Byte-enable masking.
        do_write(1, 5'd3, 4'hF, 32'hFFFFFFFF);
        do_write(1, 5'd3, 4'b0101, 32'h00000000);
        do_write(1, 5'd3, 4'b0000, 32'h12345678);
        read_expect(1, 5'd3, 32'hFF00FF00, "byte_enable");

        // Same-address write collision; s2 holds its request one more cycle.
        idle();
        cs = 2'b11; wr = 2'b11; addr = {5'd7, 5'd7}; be = {4'hF, 4'hF};
        wd = {32'h2, 32'h1};
        step();
        cs[0] = 1'b0; wr[0] = 1'b0;
        step();
        idle();
        read_expect(0, 5'd7, 32'h2, "collision");

        // Mixed-port read/write of one word returns old data.
        idle();
        cs = 2'b11; rd[0] = 1'b1; wr[1] = 1'b1; addr = {5'd7, 5'd7}; be[1] = 4'hF;
        wd[1] = 32'hCAFE0001;
        step();
        idle(); repeat (4) step();

        // Clock-enable drop while a latency-3 read is in flight.
        idle(); cs[0] = 1'b1; rd[0] = 1'b1; addr[0] = 5'd5;
        step();
        idle(); step();
        cken = 1'b0; step(); step();
        cken = 1'b1; repeat (5) step();

        // Out-of-range accesses.
        do_write(0, 5'd20, 4'hF, 32'hDEADBEEF);
        read_expect(0, 5'd20, 32'h0, "out_of_range");

        // Reset with a read in flight, then reset again mid-clear.
        idle(); cs[1] = 1'b1; rd[1] = 1'b1; addr[1] = 5'd5;
        step();
        idle(); rst = 1'b1; step();
        rst = 1'b0;
        repeat (8) step();
        rst = 1'b1; step();
        rst = 1'b0;
        clear_and_count("clear_restart");

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            rst  = ($urandom_range(0, 999) == 0);
            cken = ($urandom_range(0, 9) != 0);
            for (int p = 0; p < 2; p++) begin
                cs[p]   = ($urandom_range(0, 3) != 0);
                rd[p]   = $urandom_range(0, 1) == 1;
                wr[p]   = ($urandom_range(0, 2) == 0);
                addr[p] = 5'($urandom_range(0, 19));
                be[p]   = 4'($urandom);
                wd[p]   = $urandom;
            end
            if ($urandom_range(0, 3) == 0) addr[1] = addr[0];
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
